word_serializer: RTL and testbench
==================================

# word_serializer

- Parametrised successor to the two-byte UART chunker.
- Accepts `WORD_BYTES`-byte words over a valid/ready handshake and buffers them in a `DEPTH`-entry FIFO.
- Emits each word one byte at a time to the UART transmitter. Byte order is selectable.
- Paces every byte on the transmitter's busy flag, so no word is lost or interleaved.
- Sits between the RSA datapath result register and the UART TX.

## Interface
Parameters:
- `WORD_BYTES`, default 2: bytes per input word; must be ≥1.
- `DEPTH_LOG2`, default 1: FIFO depth is 2^`DEPTH_LOG2` words; must be ≥1.
- `MSB_FIRST`, default 1:
  - 1: most-significant byte is sent first.
  - 0: least-significant byte is sent first.

Ports:
- `iCE_CLK`  in  1  sole clock; everything is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_word`  in  8*`WORD_BYTES`  word to serialise.
- `in_valid`  in  1  `in_word` is valid.
- `in_ready`  out  1  FIFO can accept a word.
- `is_transmitting`  in  1  UART TX busy flag.
- `tx_byte`  out  8  byte to the UART.
- `tx_valid`  out  1  one-cycle strobe that starts a UART byte.
- `busy`  out  1  high when the FIFO is non-empty or the FSM is not in `IDLE`.

## Operation
- **FIFO:**
  - Write when `in_valid && in_ready`.
  - `in_ready = !full`, derived from the registered occupancy count (`DEPTH_LOG2`+1 bits).
  - A write attempted while full is ignored. Sources must hold the word until `in_ready`.
  - Pointers wrap modulo 2^`DEPTH_LOG2`.
  - A push and pop in the same cycle leave the count unchanged.
- **Shift register:** 8*`WORD_BYTES` wide, plus a byte index counter of width clog2(`WORD_BYTES`+1).
  - `MSB_FIRST=1`: the current byte is bits [top:top-7], and the register shifts left by 8.
  - `MSB_FIRST=0`: the current byte is bits [7:0], and the register shifts right by 8.
- **FSM states:**
  - `IDLE`: if the FIFO is non-empty, pop the head word into the shift register, drive `tx_byte` with byte 0, pulse `tx_valid`, set index=1, and go to `WAIT_START`.
  - `WAIT_START`: hold until `is_transmitting`=1, then go to `WAIT_DONE`. There is no timeout.
  - `WAIT_DONE`: hold until `is_transmitting`=0. Then:
    - if index < `WORD_BYTES`: drive the next byte, pulse `tx_valid`, increment index, go to `WAIT_START`;
    - otherwise go to `IDLE`, or to `CSUM` when it is compiled in (see Configuration).
  - `CSUM` (compiled in only): drive the checksum byte, pulse `tx_valid`, go to `WAIT_CSUM`.
  - `WAIT_CSUM`: wait for `is_transmitting` to rise then fall (as in `WAIT_START` and `WAIT_DONE`), then go to `IDLE`.
- `tx_valid` is registered and is never high for two consecutive cycles.
- `tx_byte` holds its value between strobes.
- `in_word` is sampled only at FIFO write; later changes to the input have no effect.

## Timing
- **Reset (`rst_n`=0, asynchronous):**
  - `tx_valid`=0, `tx_byte`=8'h00, `busy`=0.
  - FIFO emptied, state `IDLE`, index 0, checksum 0.
  - `in_ready`=0 while `rst_n`=0, and 1 from the first edge after release.
- **Reset mid-word:** the partially sent word and all FIFO contents are discarded. Nothing resumes.
- **Latency:**
  - Word written at edge k into an empty FIFO with the FSM in `IDLE`: `tx_valid`=1 in the cycle following edge k+1.
  - After `is_transmitting` falls (sampled low at edge m), the next `tx_valid` follows edge m.
- **Minimum byte spacing:** 3 cycles (strobe, `WAIT_START`, `WAIT_DONE`), plus the UART's busy time.
- **Back-to-back words:** `WAIT_DONE`→`IDLE`→next pop costs one extra cycle.
- **Glitch handling:** `is_transmitting` falling in `WAIT_START` before it ever rose is ignored.
- **Capacity:** 2^`DEPTH_LOG2` words in the FIFO plus 1 word in the shift register.

## Configuration
- **`WORD_SERIALIZER_CSUM_EN` defined:**
  - After the last data byte of each word, a checksum byte is sent: the XOR of all `WORD_BYTES` data bytes.
  - The XOR is accumulated as bytes are loaded and is cleared on each pop.
  - Each word occupies `WORD_BYTES`+1 UART bytes.
- **Undefined:**
  - `CSUM`, `WAIT_CSUM` and the accumulator are absent.
  - `WAIT_DONE` on the last byte goes directly to `IDLE`.

## Test plan
The UART model raises `is_transmitting` one cycle after `tx_valid` and holds it high for 10 cycles.

- **MSB first:** `WORD_BYTES`=2, `MSB_FIRST`=1, write 16'hA55A → `tx_byte` strobes 8'hA5 then 8'h5A, `busy` falls after the second byte. With CSUM enabled, a third strobe of 8'hFF follows.
- **LSB first:** `MSB_FIRST`=0, `WORD_BYTES`=4, write 32'h12345678 → strobes 8'h78, 8'h56, 8'h34, 8'h12. With CSUM enabled, 8'h08 follows.
- **Backpressure:** `DEPTH_LOG2`=1, hold `in_valid`=1 with words 16'h0001..16'h0004.
  - Three words are accepted in the first 3 cycles; then `in_ready`=0.
  - `in_ready` returns to 1 one cycle after the second word is popped.
  - Output byte stream is 00 01 00 02 00 03 00 04, with no loss or duplication.
- **Slow UART start:** delay the rise of `is_transmitting` by 5 cycles → exactly one `tx_valid` pulse per byte, and no byte is issued until the previous busy period ends.
- **Reset mid-word:** pull `rst_n` low during `WAIT_DONE` of byte 2 of 16'hBEEF with 2 words queued.
  - `tx_valid`=0 and `busy`=0 immediately.
  - After release, writing 16'h1234 yields 8'h12 then 8'h34 only.

Source files
------------

// File: rtl/word_serializer.sv
// Buffers WORD_BYTES-wide words in a small FIFO and sends them one byte at a time to a UART TX,
// pacing each byte on the transmitter busy flag. Define WORD_SERIALIZER_CSUM_EN to append an XOR checksum byte per word.
module word_serializer #(
  parameter int WORD_BYTES = 2,
  parameter int DEPTH_LOG2 = 1,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                    iCE_CLK,
  input  logic                    rst_n,
  input  logic [8*WORD_BYTES-1:0] in_word,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    is_transmitting,
  output logic [7:0]              tx_byte,
  output logic                    tx_valid,
  output logic                    busy
);

  // state       | meaning
  // S_IDLE      | waiting for a word in the FIFO; pops it and strobes byte 0
  // S_WAIT_START| byte strobed, waiting for the UART busy flag to rise
  // S_WAIT_DONE | UART busy, waiting for it to fall; then next byte or word end
  // S_CSUM      | strobes the checksum byte (checksum build only)
  // S_WAIT_CSUM | checksum strobed, waiting for busy to rise
  // S_CSUM_DONE | waiting for busy to fall after the checksum byte

  localparam int W     = 8 * WORD_BYTES;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int IDX_W = $clog2(WORD_BYTES + 1);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(WORD_BYTES);
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

`ifdef WORD_SERIALIZER_CSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_START, S_WAIT_DONE, S_CSUM, S_WAIT_CSUM, S_CSUM_DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_WAIT_START, S_WAIT_DONE
  } state_t;
`endif

  state_t state_q, state_d;

  logic [W-1:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  rdy_q;
  logic                  push, pop, full, empty;
  logic [W-1:0]          head_word;

  logic [W-1:0]     sh_q, sh_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_valid_q, tx_valid_d;
`ifdef WORD_SERIALIZER_CSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  function automatic logic [7:0] cur_byte(input logic [W-1:0] w);
    if (MSB_FIRST) return w[W-1 -: 8];
    else           return w[7:0];
  endfunction

  function automatic logic [W-1:0] shift_out(input logic [W-1:0] w);
    if (MSB_FIRST) return w << 8;
    else           return w >> 8;
  endfunction

  // in_ready stays low until the first edge after reset release
  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign in_ready  = rdy_q && !full;
  assign push      = in_valid && in_ready;
  assign head_word = mem_q[rd_ptr_q];

  always_ff @(posedge iCE_CLK) begin
    if (push) mem_q[wr_ptr_q] <= in_word;
  end

  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (!empty) state_d = S_WAIT_START;
      S_WAIT_START: if (is_transmitting) state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (!is_transmitting) begin
          if (idx_q < LAST_IDX) state_d = S_WAIT_START;
`ifdef WORD_SERIALIZER_CSUM_EN
          else                  state_d = S_CSUM;
`else
          else                  state_d = S_IDLE;
`endif
        end
      end
`ifdef WORD_SERIALIZER_CSUM_EN
      S_CSUM:       state_d = S_WAIT_CSUM;
      S_WAIT_CSUM:  if (is_transmitting) state_d = S_CSUM_DONE;
      S_CSUM_DONE:  if (!is_transmitting) state_d = S_IDLE;
`endif
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop        = 1'b0;
    tx_valid_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    sh_d       = sh_q;
    idx_d      = idx_q;
`ifdef WORD_SERIALIZER_CSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          tx_valid_d = 1'b1;
          tx_byte_d  = cur_byte(head_word);
          sh_d       = shift_out(head_word);
          idx_d      = IDX_W'(1);
`ifdef WORD_SERIALIZER_CSUM_EN
          csum_d     = cur_byte(head_word);
`endif
        end
      end
      S_WAIT_DONE: begin
        if (!is_transmitting && (idx_q < LAST_IDX)) begin
          tx_valid_d = 1'b1;
          tx_byte_d  = cur_byte(sh_q);
          sh_d       = shift_out(sh_q);
          idx_d      = idx_q + IDX_W'(1);
`ifdef WORD_SERIALIZER_CSUM_EN
          csum_d     = csum_q ^ cur_byte(sh_q);
`endif
        end
      end
`ifdef WORD_SERIALIZER_CSUM_EN
      S_CSUM: begin
        tx_valid_d = 1'b1;
        tx_byte_d  = csum_q;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      sh_q       <= '0;
      idx_q      <= '0;
`ifdef WORD_SERIALIZER_CSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_byte_q  <= tx_byte_d;
      sh_q       <= sh_d;
      idx_q      <= idx_d;
`ifdef WORD_SERIALIZER_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_byte  = tx_byte_q;
  assign busy     = !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: directed table, multi-cycle corner sequences and random words
// checked against a byte-stream reference model with a behavioural UART busy model.
module tb_word_serializer;
  localparam int WB = 2;
`ifdef WORD_SERIALIZER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_word = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, tx_valid, busy;
  logic [7:0]  tx_byte;
  logic        is_tx;

  logic [31:0] in_word4 = '0;
  logic        in_valid4 = 1'b0;
  logic        in_ready4, tx_valid4, busy4;
  logic [7:0]  tx_byte4;
  logic        is_tx4;

  always #5 clk = ~clk;

  word_serializer #(.WORD_BYTES(2), .DEPTH_LOG2(1), .MSB_FIRST(1'b1)) u_dut (
    .iCE_CLK(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
    .is_transmitting(is_tx), .tx_byte(tx_byte), .tx_valid(tx_valid), .busy(busy));

  word_serializer #(.WORD_BYTES(4), .DEPTH_LOG2(2), .MSB_FIRST(1'b0)) u_dut4 (
    .iCE_CLK(clk), .rst_n(rst_n), .in_word(in_word4), .in_valid(in_valid4), .in_ready(in_ready4),
    .is_transmitting(is_tx4), .tx_byte(tx_byte4), .tx_valid(tx_valid4), .busy(busy4));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // UART: busy rises start_dly cycles after the strobe is seen, stays high 10 cycles
  int start_dly = 0;
  int dcnt, bcnt, bcnt4;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_tx <= 1'b0; dcnt <= 0; bcnt <= 0;
    end else if (tx_valid) begin
      if (start_dly == 0) begin is_tx <= 1'b1; bcnt <= 9; end
      else dcnt <= start_dly;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) begin is_tx <= 1'b1; bcnt <= 9; end
    end else if (is_tx) begin
      if (bcnt == 0) is_tx <= 1'b0;
      else bcnt <= bcnt - 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_tx4 <= 1'b0; bcnt4 <= 0;
    end else if (tx_valid4) begin
      is_tx4 <= 1'b1; bcnt4 <= 9;
    end else if (is_tx4) begin
      if (bcnt4 == 0) is_tx4 <= 1'b0;
      else bcnt4 <= bcnt4 - 1;
    end
  end

  logic [7:0] cap_q[$];
  logic [7:0] cap4_q[$];
  logic [7:0] exp_q[$];
  bit prev_tv = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) prev_tv = 1'b0;
    else begin
      if (tx_valid) begin
        chk("strobe_consecutive", 32'(prev_tv), 32'd0);
        chk("strobe_while_uart_busy", 32'(is_tx), 32'd0);
        cap_q.push_back(tx_byte);
      end
      prev_tv = tx_valid;
      if (tx_valid4) cap4_q.push_back(tx_byte4);
    end
  end

  // reference: bytes of a word in send order, then XOR checksum when compiled in
  function automatic void model_push(input logic [15:0] w);
    logic [7:0] x, b;
    x = 8'h00;
    for (int i = 0; i < WB; i++) begin
      b = 8'(w >> (8 * (WB - 1 - i)));
      exp_q.push_back(b);
      x ^= b;
    end
    if (CSUM) exp_q.push_back(x);
  endfunction

  task automatic send(input logic [15:0] w);
    bit ok;
    ok = 1'b0;
    in_word  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        model_push(w);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int i;
    for (i = 0; i < budget && cap_q.size() < n; i++) @(negedge clk);
    if (cap_q.size() < n) chk("byte_wait_timeout", 32'(cap_q.size()), 32'(n));
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic cmp_stream(input string name);
    logic [31:0] act;
    chk($sformatf("%s_len", name), 32'(cap_q.size()), 32'(exp_q.size()));
    for (int j = 0; j < exp_q.size(); j++) begin
      act = (j < cap_q.size()) ? 32'(cap_q[j]) : 'x;
      chk($sformatf("%s_byte%0d", name, j), act, 32'(exp_q[j]));
    end
  endtask

  typedef struct {
    logic [15:0] word;
    int          dly;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  cs;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int nxt, acc;
    logic [7:0] exp4[$];
    logic [31:0] act;
    logic [15:0] w;

    tbl[0] = '{16'hA55A, 0, 8'hA5, 8'h5A, 8'hFF};
    tbl[1] = '{16'h1234, 2, 8'h12, 8'h34, 8'h26};
    tbl[2] = '{16'hFFFF, 5, 8'hFF, 8'hFF, 8'h00};
    tbl[3] = '{16'h0000, 0, 8'h00, 8'h00, 8'h00};
    tbl[4] = '{16'h00FF, 1, 8'h00, 8'hFF, 8'hFF};

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    rst_n = 1'b1;
    #1 chk("in_ready_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("in_ready_after_edge", 32'(in_ready), 32'd1);
    chk("in_ready4_after_edge", 32'(in_ready4), 32'd1);

    // first-byte latency: strobe in the cycle after edge k+1
    cap_q.delete(); exp_q.delete();
    in_word = 16'h5AA5; in_valid = 1'b1;
    model_push(16'h5AA5);
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_no_strobe_k", 32'(tx_valid), 32'd0);
    @(negedge clk);
    chk("lat_strobe_k1", 32'(tx_valid), 32'd1);
    chk("lat_byte0", 32'(tx_byte), 32'h5A);
    wait_bytes(exp_q.size(), 300);
    wait_idle("lat_idle");
    cmp_stream("lat");

    // table vectors
    for (int i = 0; i < 5; i++) begin
      start_dly = tbl[i].dly;
      cap_q.delete(); exp_q.delete();
      send(tbl[i].word);
      exp_q.delete();
      exp_q.push_back(tbl[i].b0);
      exp_q.push_back(tbl[i].b1);
      if (CSUM) exp_q.push_back(tbl[i].cs);
      wait_bytes(exp_q.size(), 400);
      wait_idle($sformatf("tbl%0d_idle", i));
      cmp_stream($sformatf("tbl%0d", i));
    end

    // backpressure with in_valid held high
    start_dly = 0;
    cap_q.delete(); exp_q.delete();
    nxt = 1; acc = 0;
    in_word = 16'(nxt); in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (in_ready) begin model_push(in_word); acc++; nxt++; end
      @(negedge clk);
      in_word = 16'(nxt);
    end
    chk("bp_accepted_3", 32'(acc), 32'd3);
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    for (int c = 0; c < 400 && nxt <= 4; c++) begin
      if (in_ready) begin model_push(in_word); acc++; nxt++; end
      @(negedge clk);
      in_word = 16'(nxt);
    end
    in_valid = 1'b0;
    chk("bp_accepted_4", 32'(acc), 32'd4);
    wait_bytes(exp_q.size(), 800);
    wait_idle("bp_idle");
    cmp_stream("bp");

    // slow UART start
    start_dly = 5;
    cap_q.delete(); exp_q.delete();
    send(16'hC3E1);
    send(16'h7E81);
    wait_bytes(exp_q.size(), 800);
    wait_idle("slow_idle");
    cmp_stream("slow");

    // reset in WAIT_DONE of byte 2 with two words queued
    start_dly = 0;
    cap_q.delete(); exp_q.delete();
    send(16'hBEEF);
    send(16'h1111);
    send(16'h2222);
    wait_bytes(2, 400);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cap_q.delete(); exp_q.delete();
    send(16'h1234);
    wait_bytes(exp_q.size(), 400);
    repeat (60) @(negedge clk);
    chk("midrst_idle", 32'(busy), 32'd0);
    cmp_stream("midrst");

    // LSB-first, 4-byte instance
    cap4_q.delete();
    exp4 = '{8'h78, 8'h56, 8'h34, 8'h12};
    if (CSUM) exp4.push_back(8'h08);
    in_word4 = 32'h12345678; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    in_word4 = 32'hDEADBEEF;
    for (int i = 0; i < 400 && cap4_q.size() < exp4.size(); i++) @(negedge clk);
    repeat (30) @(negedge clk);
    chk("lsb4_len", 32'(cap4_q.size()), 32'(exp4.size()));
    for (int j = 0; j < exp4.size(); j++) begin
      act = (j < cap4_q.size()) ? 32'(cap4_q[j]) : 'x;
      chk($sformatf("lsb4_byte%0d", j), act, 32'(exp4[j]));
    end
    chk("lsb4_idle", 32'(busy4), 32'd0);

    // random words, gaps and UART start delays
    cap_q.delete(); exp_q.delete();
    for (int n = 0; n < 40; n++) begin
      start_dly = $urandom_range(0, 3);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      w = 16'($urandom);
      send(w);
    end
    wait_bytes(exp_q.size(), 6000);
    wait_idle("rand_idle");
    cmp_stream("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
